// File: rtl/divider_signed_pipelined.sv
// divider_signed_pipelined: restoring divider, BITS_PER_STAGE quotient bits per register stage,
// RISC-V DIV/DIVU/REM/REMU semantics with valid/tag sideband and global stall.
module divider_signed_pipelined #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_STAGE = 4,
    parameter int TAG_W          = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             i_valid,
    input  logic             i_signed,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic [TAG_W-1:0] o_tag,
    output logic             o_div_by_zero
);
    localparam int STAGES = WIDTH / BITS_PER_STAGE;
    localparam int L = STAGES - 1;

    logic [WIDTH-1:0] rem_q [STAGES];
    logic [WIDTH-1:0] dq_q  [STAGES];
    logic [WIDTH-1:0] dvs_q [STAGES];
    logic [TAG_W-1:0] tag_q [STAGES];
    logic [STAGES-1:0] nq_q, nr_q, dz_q, vld_q;

    logic neg_a, neg_b;
    logic [WIDTH-1:0] mag_a, mag_b;

    assign neg_a = i_signed & i_dividend[WIDTH-1];
    assign neg_b = i_signed & i_divisor[WIDTH-1];
    assign mag_a = neg_a ? -i_dividend : i_dividend;
    assign mag_b = neg_b ? -i_divisor : i_divisor;

    // dq holds the not-yet-consumed dividend bits on top and the quotient bits shifted in below
    function automatic logic [2*WIDTH-1:0] step(input logic [WIDTH-1:0] r0, d0, v);
        logic [WIDTH-1:0] r, d;
        logic [WIDTH:0] sh;
        logic ge;
        r = r0;
        d = d0;
        for (int i = 0; i < BITS_PER_STAGE; i++) begin
            sh = {r, d[WIDTH-1]};
            ge = sh >= {1'b0, v};
            r  = ge ? WIDTH'(sh - {1'b0, v}) : sh[WIDTH-1:0];
            d  = {d[WIDTH-2:0], ge};
        end
        return {r, d};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < STAGES; s++) begin
                rem_q[s] <= '0;
                dq_q[s]  <= '0;
                dvs_q[s] <= '0;
                tag_q[s] <= '0;
            end
            nq_q  <= '0;
            nr_q  <= '0;
            dz_q  <= '0;
            vld_q <= '0;
        end else if (!stall) begin
            {rem_q[0], dq_q[0]} <= step('0, mag_a, mag_b);
            dvs_q[0] <= mag_b;
            tag_q[0] <= i_tag;
            nq_q[0]  <= neg_a ^ neg_b;
            nr_q[0]  <= neg_a;
            dz_q[0]  <= i_divisor == '0;
            vld_q[0] <= i_valid;
            for (int s = 1; s < STAGES; s++) begin
                {rem_q[s], dq_q[s]} <= step(rem_q[s-1], dq_q[s-1], dvs_q[s-1]);
                dvs_q[s] <= dvs_q[s-1];
                tag_q[s] <= tag_q[s-1];
                nq_q[s]  <= nq_q[s-1];
                nr_q[s]  <= nr_q[s-1];
                dz_q[s]  <= dz_q[s-1];
                vld_q[s] <= vld_q[s-1];
            end
        end
    end

    // a zero divisor leaves |dividend| in the remainder, so the sign fix-up restores the dividend
    assign o_valid       = vld_q[L];
    assign o_tag         = tag_q[L];
    assign o_div_by_zero = dz_q[L];
    assign o_quotient    = dz_q[L] ? '1 : nq_q[L] ? -dq_q[L] : dq_q[L];
    assign o_remainder   = nr_q[L] ? -rem_q[L] : rem_q[L];
endmodule
